// File: rtl/mac_tx_arb.sv
// Transmit arbiter: N frame sources share one MAC transmit port, with a grant per frame,
// an inter-frame gap and a payload-length watchdog. Define MAC_TX_ARB_PRIO_EN for fixed priority.
package mac_tx_arb_pkg;
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } mac_hdr_t;
endpackage

module mac_tx_arb
  import mac_tx_arb_pkg::*;
#(
  parameter int N          = 2,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_avl,
  input  mac_hdr_t [N-1:0]    req_hdr,
  input  logic [N-1:0][7:0]   req_d,
  input  logic [N-1:0]        req_v,
  input  logic [N-1:0]        req_eof,
  output logic [N-1:0]        req_rdy,
  output logic [N-1:0]        req_err,
  output logic                mac_avl,
  output mac_hdr_t            mac_hdr,
  input  logic                mac_rdy,
  output logic [7:0]          mac_d,
  output logic                mac_v,
  output logic                mac_sof,
  output logic                mac_eof,
  output logic                mac_err,
  output logic [N-1:0]        gnt
);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, XFER, GAP} state_t;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] win_q, win_d, last_q, last_d, pick;
  logic [N-1:0]  gnt_q, gnt_d, rdy_q, rdy_d, err_q, err_d, drop_q, drop_d, elig;
  mac_hdr_t      hdr_q, hdr_d;
  logic          avl_q, avl_d, v_q, v_d, sof_q, sof_d, eof_q, eof_d, first_q, first_d;
  logic [7:0]    d_q, d_d;
  logic [15:0]   cnt_q, cnt_d, cnt_inc, gap_q, gap_d;
  logic          found, to_gap;

  // A requester cut off by the watchdog stays out of arbitration until it drops req_avl.
  always_comb begin : arb
`ifndef MAC_TX_ARB_PRIO_EN
    int idx;
`endif
    elig  = req_avl & ~drop_q;
    found = 1'b0;
    pick  = '0;
`ifdef MAC_TX_ARB_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
`endif
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin : fsm
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    hdr_d   = hdr_q;
    avl_d   = avl_q;
    rdy_d   = '0;
    err_d   = '0;
    d_d     = d_q;
    v_d     = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    first_d = first_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    drop_d  = drop_q & req_avl;
    cnt_inc = cnt_q + 16'd1;
    to_gap  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          hdr_d       = req_hdr[pick];
          avl_d       = 1'b1;
          state_d     = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (!req_avl[win_q]) begin
          avl_d  = 1'b0;
          to_gap = 1'b1;
        end else if (mac_rdy) begin
          avl_d        = 1'b0;
          rdy_d[win_q] = 1'b1;
          cnt_d        = '0;
          first_d      = 1'b1;
          state_d      = XFER;
        end
      end
      XFER: begin
        d_d = req_d[win_q];
        if (req_v[win_q]) begin
          v_d     = 1'b1;
          sof_d   = first_q;
          first_d = 1'b0;
          cnt_d   = cnt_inc;
          if (req_eof[win_q]) begin
            eof_d  = 1'b1;
            to_gap = 1'b1;
          end else if (cnt_inc == 16'(MAX_LEN)) begin
            eof_d         = 1'b1;
            err_d[win_q]  = 1'b1;
            drop_d[win_q] = 1'b1;
            to_gap        = 1'b1;
          end
        end
      end
      GAP: begin
        // A zero-length gap still spends one cycle here.
        if (IFG_CYCLES <= 1 || gap_q == 16'(IFG_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (to_gap) begin
      gnt_d   = '0;
      last_d  = win_q;
      gap_d   = '0;
      state_d = GAP;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(N - 1);
      gnt_q   <= '0;
      hdr_q   <= '0;
      avl_q   <= 1'b0;
      rdy_q   <= '0;
      err_q   <= '0;
      d_q     <= '0;
      v_q     <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      hdr_q   <= hdr_d;
      avl_q   <= avl_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      d_q     <= d_d;
      v_q     <= v_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
    end
  end

  assign gnt     = gnt_q;
  assign req_rdy = rdy_q;
  assign req_err = err_q;
  assign mac_avl = avl_q;
  assign mac_hdr = hdr_q;
  assign mac_d   = d_q;
  assign mac_v   = v_q;
  assign mac_sof = sof_q;
  assign mac_eof = eof_q;
  assign mac_err = 1'b0;

endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed bench for mac_tx_arb (N=2, IFG_CYCLES=12, MAX_LEN=64) with a payload scoreboard.
module tb_mac_tx_arb;
  import mac_tx_arb_pkg::*;

  localparam int N       = 2;
  localparam int IFG     = 12;
  localparam int MAX_LEN = 64;
`ifdef MAC_TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clk, rst;
  logic [N-1:0]        req_avl, req_v, req_eof, req_rdy, req_err, gnt;
  mac_hdr_t [N-1:0]    req_hdr;
  logic [N-1:0][7:0]   req_d;
  logic                mac_avl, mac_rdy, mac_v, mac_sof, mac_eof, mac_err;
  mac_hdr_t            mac_hdr;
  logic [7:0]          mac_d;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n;

  mac_tx_arb #(.N(N), .IFG_CYCLES(IFG), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .req_avl(req_avl), .req_hdr(req_hdr), .req_d(req_d), .req_v(req_v), .req_eof(req_eof),
    .req_rdy(req_rdy), .req_err(req_err),
    .mac_avl(mac_avl), .mac_hdr(mac_hdr), .mac_rdy(mac_rdy), .mac_d(mac_d), .mac_v(mac_v),
    .mac_sof(mac_sof), .mac_eof(mac_eof), .mac_err(mac_err), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every byte leaving the MAC side must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (rst && mac_v) begin
      if (sb.size() == 0) check("mac_v_unexpected", mac_v, 1'b0);
      else begin
        e = sb.pop_front();
        check("mac_d", mac_d, e.d);
        check("mac_sof", mac_sof, e.sof);
        check("mac_eof", mac_eof, e.eof);
      end
    end
  end

  task automatic wait_grant(input int w, output int cnt);
    cnt = 0;
    while (gnt === '0 && cnt < 64) begin
      tick;
      cnt++;
    end
    check("grant", gnt, 2'b1 << w);
    check("grant_avl", mac_avl, 1'b1);
    check("grant_hdr", mac_hdr, req_hdr[w]);
  endtask

  // Streams nbytes from requester w while the other requester drives ignored noise.
  task automatic stream(input int w, input int nbytes, input bit eof_last);
    for (int k = 0; k < nbytes; k++) begin
      req_v = '1;
      for (int i = 0; i < N; i++) begin
        req_d[i]   = (i == w) ? 8'(k * 7 + w + 1) : 8'hEE;
        req_eof[i] = (i == w) ? (eof_last && k == nbytes - 1) : 1'b1;
      end
      if (k < MAX_LEN)
        sb.push_back('{8'(k * 7 + w + 1), k == 0, (eof_last && k == nbytes - 1) || k == MAX_LEN - 1});
      tick;
      check("latency_v", mac_v, k < MAX_LEN);
      if (k == 0) check("req_rdy_pulse", req_rdy, 2'b00);
      if (!eof_last && k == MAX_LEN - 1) check("req_err", req_err, 2'b1 << w);
      if (!eof_last && k == MAX_LEN) check("req_err_pulse", req_err, 2'b00);
    end
    if (eof_last) check("no_err", req_err, 2'b00);
    req_v   = '0;
    req_eof = '0;
  endtask

  task automatic run_frame(input int w, input int nbytes, input bit eof_last, input int rdy_delay);
    int c;
    wait_grant(w, c);
    for (int i = 0; i < rdy_delay; i++) begin
      tick;
      check("wait_rdy_hold", {mac_avl, req_rdy}, {1'b1, 2'b00});
    end
    mac_rdy = 1'b1;
    tick;
    mac_rdy = 1'b0;
    check("req_rdy", req_rdy, 2'b1 << w);
    check("avl_clear", mac_avl, 1'b0);
    stream(w, nbytes, eof_last);
    check("gnt_after", gnt, 2'b00);
    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b0;
    req_avl = '0;
    req_v   = '0;
    req_eof = '0;
    req_d   = '0;
    mac_rdy = 1'b0;
    req_hdr[0] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0806};
    req_hdr[1] = '{48'h0200_0000_00AA, 48'h0200_0000_0001, 16'h0800};
    tick;
    tick;
    check("reset_hdr", mac_hdr, '0);
    check("reset_ctl", {gnt, req_rdy, req_err, mac_avl, mac_d, mac_v, mac_sof, mac_eof, mac_err}, '0);
    rst = 1'b1;
    tick;

    // Both requesters always ready: alternate grants (all to 0 in the priority build).
    req_avl = 2'b11;
    for (int f = 0; f < 4; f++) run_frame(PRIO ? 0 : f % 2, 4, 1'b1, 0);
    req_avl = 2'b00;

    // Single request on 1 (IPv4), late mac_rdy, then the gap must hold off requester 0.
    req_avl = 2'b10;
    run_frame(1, 46, 1'b1, 3);
    req_avl = 2'b01;
    for (int i = 0; i < IFG; i++) begin
      tick;
      check("ifg_gnt", gnt, 2'b00);
    end
    wait_grant(0, n);
    check("ifg_len", n, 1);
    mac_rdy = 1'b1;
    tick;
    mac_rdy = 1'b0;
    check("req_rdy_0", req_rdy, 2'b01);
    stream(0, 4, 1'b1);
    @(negedge clk);
    #1;
    check("sb_empty_0", sb.size(), 0);
    req_avl = 2'b00;

    // Watchdog: 100 bytes without eof; the stuck requester is not regranted.
    req_avl = 2'b01;
    run_frame(0, 100, 1'b0, 1);
    req_avl = 2'b00;

    // eof on exactly the MAX_LEN-th byte is a normal end.
    req_avl = 2'b10;
    run_frame(1, MAX_LEN, 1'b1, 0);
    req_avl = 2'b00;

    // Abort: requester 0 withdraws in WAIT_RDY; requester 1 gets the next grant.
    req_avl = 2'b01;
    wait_grant(0, n);
    req_avl = 2'b10;
    tick;
    check("abort_avl", mac_avl, 1'b0);
    check("abort_gnt", gnt, 2'b00);
    for (int i = 0; i < IFG + 1; i++) begin
      tick;
      check("abort_no_rdy", req_rdy, 2'b00);
    end
    run_frame(1, 3, 1'b1, 1);
    req_avl = 2'b00;

    // Asynchronous reset mid-transfer, then a normal grant afterwards.
    req_avl = 2'b01;
    wait_grant(0, n);
    mac_rdy = 1'b1;
    tick;
    mac_rdy = 1'b0;
    check("req_rdy_rst", req_rdy, 2'b01);
    stream(0, 5, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_hdr", mac_hdr, '0);
    check("rst_ctl", {gnt, req_rdy, req_err, mac_avl, mac_d, mac_v, mac_sof, mac_eof, mac_err}, '0);
    req_avl = 2'b10;
    tick;
    tick;
    check("rst_hold", {gnt, req_rdy, mac_v}, '0);
    rst = 1'b1;
    run_frame(1, 6, 1'b1, 2);
    req_avl = 2'b00;
    tick;
    check("sb_final", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
